// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: synchronizes pll_locked, holds downstream logic in reset until lock is stable,
// then runs a 1 Hz tick. Optional lock-loss counter enabled by defining PLL_LOCK_SEQ_LOSS_CNT_EN.
module pll_lock_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_HOLD   = 2000,
    parameter int TICK_DIV    = 2000000
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clr_cnt,
    output logic       sys_rst_n,
    output logic       sys_ready,
    output logic       tick_1hz,
    output logic [7:0] lock_loss_cnt
);

    localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {WAIT_LOCK, HOLD, RUN, LOST} state_t;

    state_t                   state_reg, state_next;
    logic [SYNC_STAGES-1:0]   sync_reg;
    logic                     locked_s;
    logic [HOLD_W-1:0]        hold_cnt_reg, hold_cnt_next;
    logic [DIV_W-1:0]         div_reg, div_next;
    logic                     ready_reg, ready_next;
    logic                     tick_reg, tick_next;
    logic                     loss_event;

    // pll_locked is asynchronous; only the last synchronizer stage feeds logic
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WAIT_LOCK;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            WAIT_LOCK: begin
                hold_cnt_next = '0;
                if (locked_s) state_next = HOLD;
            end
            HOLD: begin
                // any dropout restarts the full hold window
                if (!locked_s) begin
                    state_next    = WAIT_LOCK;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    state_next    = RUN;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RUN:     if (!locked_s) state_next = LOST;
            LOST:    state_next = WAIT_LOCK;
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Outputs registered from the next state so they track the RUN state cycle-for-cycle
    always_comb begin
        ready_next = (state_next == RUN);
        div_next   = '0;
        tick_next  = 1'b0;
        if (state_reg == RUN && state_next == RUN) begin
            if (div_reg == DIV_LAST) begin
                tick_next = 1'b1;
            end else begin
                div_next = div_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            ready_reg <= 1'b0;
            tick_reg  <= 1'b0;
            div_reg   <= '0;
        end else begin
            ready_reg <= ready_next;
            tick_reg  <= tick_next;
            div_reg   <= div_next;
        end
    end

    assign sys_rst_n  = ready_reg;
    assign sys_ready  = ready_reg;
    assign tick_1hz   = tick_reg;
    assign loss_event = (state_reg == RUN) && (state_next == LOST);

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_reg, loss_cnt_next;

    // Clear wins over the old value but still records a coincident loss
    always_comb begin
        loss_cnt_next = loss_cnt_reg;
        if (clr_cnt) begin
            loss_cnt_next = {7'd0, loss_event};
        end else if (loss_event && loss_cnt_reg != 8'hFF) begin
            loss_cnt_next = loss_cnt_reg + 8'd1;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            loss_cnt_reg <= 8'd0;
        end else begin
            loss_cnt_reg <= loss_cnt_next;
        end
    end

    assign lock_loss_cnt = loss_cnt_reg;
`else
    logic unused_loss_inputs;
    assign unused_loss_inputs = clr_cnt ^ loss_event;
    assign lock_loss_cnt      = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq (LOCK_HOLD=8, TICK_DIV=10): expectations go through a scoreboard queue.
module tb_pll_lock_seq;

    localparam int LH = 8;
    localparam int TD = 10;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       sys_rst_n, sys_ready, tick_1hz;
    logic [7:0] lock_loss_cnt;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   passes = 0;
    int   total = 0;
    int   loss_model = 0;
    int   n;
    int   highs;

    always #5 refclk = ~refclk;

    pll_lock_seq #(.SYNC_STAGES(2), .LOCK_HOLD(LH), .TICK_DIV(TD)) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .clr_cnt      (clr_cnt),
        .sys_rst_n    (sys_rst_n),
        .sys_ready    (sys_ready),
        .tick_1hz     (tick_1hz),
        .lock_loss_cnt(lock_loss_cnt)
    );

    function automatic int exp_cnt(input int v);
        return CNT_EN ? v : 0;
    endfunction

    task automatic push(input string tag, input int exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input int obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) passes++;
            else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
        end
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return sys_ready === 1'b1;
            1:       return tick_1hz === 1'b1;
            2:       return sys_rst_n === 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    // Counts rising edges (checked at each following falling edge) until cond holds; -1 on timeout
    task automatic wait_until(input int which, input int limit, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = -1;
        for (int i = 1; i <= limit && !hit; i++) begin
            @(negedge refclk);
            if (cond(which)) begin
                hit    = 1'b1;
                cycles = i;
            end
        end
    endtask

    task automatic relock();
        int c;
        pll_locked = 1'b1;
        push("release_cycles", 2 + LH + 1);
        wait_until(0, 100, c);
        check(c);
        push("sys_rst_n_high", 1);
        check(int'(sys_rst_n));
    endtask

    task automatic drop();
        int c;
        pll_locked = 1'b0;
        push("drop_to_reset_cycles", 3);
        wait_until(2, 20, c);
        check(c);
        if (loss_model < 255) loss_model++;
        push("loss_cnt_after_drop", exp_cnt(loss_model));
        check(int'(lock_loss_cnt));
    endtask

    initial begin
        // reset held with the PLL already locked
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        repeat (4) @(negedge refclk);
        push("reset_sys_rst_n", 0); check(int'(sys_rst_n));
        push("reset_sys_ready", 0); check(int'(sys_ready));
        push("reset_tick", 0);      check(int'(tick_1hz));
        push("reset_loss_cnt", 0);  check(int'(lock_loss_cnt));

        rst_n = 1'b1;
        relock();

        push("first_tick_cycles", TD);
        wait_until(1, 50, n);
        check(n);
        push("tick_period", TD);
        wait_until(1, 50, n);
        check(n);
        @(negedge refclk);
        push("tick_width", 0);
        check(int'(tick_1hz));

        // lock loss in RUN: reset asserted, counter bumps, ticks stop
        drop();
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge refclk);
            if (tick_1hz) highs++;
        end
        push("tick_stopped", 0); check(highs);
        push("ready_low_lost", 0); check(int'(sys_ready));
        relock();

        // one-cycle dropout at hold count 5 restarts the hold window
        drop();
        repeat (5) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (6) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        push("glitch_release_cycles", 2 + 1 + LH);
        wait_until(0, 100, n);
        check(n);

        for (int i = 0; i < 300; i++) begin
            drop();
            relock();
        end
        push("loss_cnt_saturated", exp_cnt(255));
        check(int'(lock_loss_cnt));

        // clear coincident with a RUN-to-LOST transition
        pll_locked = 1'b0;
        @(negedge refclk);
        @(negedge refclk);
        clr_cnt = 1'b1;
        @(negedge refclk);
        clr_cnt    = 1'b0;
        loss_model = 1;
        push("clr_with_loss", exp_cnt(1)); check(int'(lock_loss_cnt));
        push("clr_loss_reset", 0);         check(int'(sys_rst_n));

        relock();
        drop();
        @(negedge refclk);
        clr_cnt = 1'b1;
        @(negedge refclk);
        clr_cnt    = 1'b0;
        loss_model = 0;
        push("clr_plain", 0); check(int'(lock_loss_cnt));

        relock();
        drop();
        relock();

        // asynchronous reset between clock edges mid-RUN
        @(posedge refclk);
        #2 rst_n = 1'b0;
        #1;
        loss_model = 0;
        push("async_sys_rst_n", 0); check(int'(sys_rst_n));
        push("async_sys_ready", 0); check(int'(sys_ready));
        push("async_tick", 0);      check(int'(tick_1hz));
        push("async_loss_cnt", 0);  check(int'(lock_loss_cnt));

        // full sequence required again though pll_locked never dropped
        @(negedge refclk);
        rst_n = 1'b1;
        relock();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
